// File: rtl/decripta_bloco_seq.sv
`default_nettype none
// ============================================================================
// Module      : decripta_bloco_seq
// Description : Iterative AES-128 block decryption engine. A ciphertext block
//               and key are accepted through a valid/ready handshake. The key
//               is expanded once per block, one inverse round is applied per
//               clock, and the plaintext is offered through a second
//               valid/ready handshake.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock             in   1    rising-edge clock
//   reset             in   1    synchronous, active-high reset
//   entrada_valida    in   1    bloco_in/chave valid
//   entrada_pronta    out  1    engine can accept a block (OCIOSO only)
//   bloco_in          in   128  ciphertext, byte 0 in bits [127:120]
//   chave             in   128  cipher key, captured on accept
//   saida_valida      out  1    bloco_out holds a finished plaintext
//   saida_pronta      in   1    downstream takes bloco_out this cycle
//   bloco_out         out  128  plaintext, same byte order as bloco_in
//   ocupado           out  1    high from accept until output handshake
//   blocos_decifrados out  16   completed output handshakes (only with
//                               DECRIPTA_CONTADOR_EN defined)
// Configuration macro: DECRIPTA_CONTADOR_EN
// ============================================================================
module decripta_bloco_seq #(
  parameter int NUM_RODADAS = 10,
  parameter int LARGURA     = 128
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               entrada_valida,
  output logic               entrada_pronta,
  input  logic [LARGURA-1:0] bloco_in,
  input  logic [LARGURA-1:0] chave,
  output logic               saida_valida,
  input  logic               saida_pronta,
  output logic [LARGURA-1:0] bloco_out,
  output logic               ocupado
`ifdef DECRIPTA_CONTADOR_EN
  ,
  output logic [15:0]        blocos_decifrados
`endif
);

  localparam int C_NPAL = 4 * (NUM_RODADAS + 1);   // 32-bit words in schedule

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    RODADA = 2'd1,
    FINAL  = 2'd2,
    SAIDA  = 2'd3
  } fsm_t;

  // ---------------- GF(2^8) and AES primitives ----------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0, as AES requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] t;
    t = gf_mul(gf_mul(x, x), x);         // x^3
    t = gf_mul(gf_mul(t, t), x);         // x^7
    t = gf_mul(gf_mul(t, t), x);         // x^15
    t = gf_mul(gf_mul(t, t), x);         // x^31
    t = gf_mul(gf_mul(t, t), x);         // x^63
    t = gf_mul(gf_mul(t, t), x);         // x^127
    return gf_mul(t, t);                 // x^254
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
           {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] b;
    b = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

  // Byte n = row + 4*col lives at bits [127-8n -: 8].
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int n = 0; n < 16; n++) o[127-8*n -: 8] = inv_sbox(s[127-8*n -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0,8'h0e)^gf_mul(a1,8'h0b)^gf_mul(a2,8'h0d)^gf_mul(a3,8'h09);
      o[119-32*c -: 8] = gf_mul(a0,8'h09)^gf_mul(a1,8'h0e)^gf_mul(a2,8'h0b)^gf_mul(a3,8'h0d);
      o[111-32*c -: 8] = gf_mul(a0,8'h0d)^gf_mul(a1,8'h09)^gf_mul(a2,8'h0e)^gf_mul(a3,8'h0b);
      o[103-32*c -: 8] = gf_mul(a0,8'h0b)^gf_mul(a1,8'h0d)^gf_mul(a2,8'h09)^gf_mul(a3,8'h0e);
    end
    return o;
  endfunction

  // Round keys 1..NUM_RODADAS; round key r at [top - 128*(r-1) -: 128].
  function automatic logic [128*NUM_RODADAS-1:0] expand_key(input logic [127:0] k);
    logic [31:0]                 w [0:C_NPAL-1];
    logic [31:0]                 t;
    logic [7:0]                  rcon;
    logic [128*NUM_RODADAS-1:0]  e;
    rcon = 8'h01;
    e    = '0;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < C_NPAL; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t    = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rcon, 24'h0};
        rcon = xtime(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 4; i < C_NPAL; i++) e[128*NUM_RODADAS-1-32*(i-4) -: 32] = w[i];
    return e;
  endfunction

  // ---------------- State ----------------
  fsm_t                       r_fsm, w_fsm_prox;
  logic [127:0]               r_estado;
  logic [127:0]               r_chave;
  logic [3:0]                 r_rodada;
  logic [127:0]               r_bloco_out;
  logic                       r_saida_valida;

  logic [127:0]               w_chave_src;
  logic [128*NUM_RODADAS-1:0] w_exp;
  logic [3:0]                 w_sel;
  logic [127:0]               w_rk;
  logic [127:0]               w_inv_base;

  // One expansion unit serves both the accept cycle (live key, for rk10) and
  // the rounds (registered key), so the schedule logic is not duplicated.
  assign w_chave_src = (r_fsm == OCIOSO) ? chave : r_chave;
  assign w_exp       = expand_key(w_chave_src);
  // Counter is 0 outside RODADA; clamp so the slice never leaves the vector.
  assign w_sel       = (r_rodada == 4'd0) ? 4'd1 : r_rodada;
  assign w_rk        = w_exp[128*(NUM_RODADAS - int'(w_sel)) +: 128];
  assign w_inv_base  = inv_sub_bytes(inv_shift_rows(r_estado));

  always_ff @(posedge clock) begin
    if (reset) r_fsm <= OCIOSO;
    else       r_fsm <= w_fsm_prox;
  end

  always_comb begin
    w_fsm_prox = r_fsm;
    case (r_fsm)
      OCIOSO:  if (entrada_valida) w_fsm_prox = RODADA;
      RODADA:  if (r_rodada == 4'd1) w_fsm_prox = FINAL;
      FINAL:   w_fsm_prox = SAIDA;
      SAIDA:   if (saida_pronta) w_fsm_prox = OCIOSO;
      default: w_fsm_prox = OCIOSO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado       <= '0;
      r_chave        <= '0;
      r_rodada       <= 4'd0;
      r_bloco_out    <= '0;
      r_saida_valida <= 1'b0;
    end else begin
      case (r_fsm)
        OCIOSO: if (entrada_valida) begin
          r_estado <= bloco_in ^ w_exp[127:0];
          r_chave  <= chave;
          r_rodada <= 4'(NUM_RODADAS - 1);
        end
        RODADA: begin
          r_estado <= inv_mix_columns(w_inv_base ^ w_rk);
          r_rodada <= r_rodada - 4'd1;
        end
        FINAL: begin
          r_bloco_out    <= w_inv_base ^ r_chave;
          r_saida_valida <= 1'b1;
        end
        SAIDA: if (saida_pronta) r_saida_valida <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef DECRIPTA_CONTADOR_EN
  logic [15:0] r_contador;
  always_ff @(posedge clock) begin
    if (reset)                            r_contador <= 16'h0000;
    else if (r_saida_valida && saida_pronta) r_contador <= r_contador + 16'h0001;
  end
  assign blocos_decifrados = r_contador;
`endif

  assign entrada_pronta = (r_fsm == OCIOSO);
  assign ocupado        = (r_fsm != OCIOSO);
  assign saida_valida   = r_saida_valida;
  assign bloco_out      = r_bloco_out;

endmodule
`default_nettype wire

// File: tb/tb_decripta_bloco_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_decripta_bloco_seq
// Description : Directed self-checking bench for decripta_bloco_seq using
//               FIPS-197 vectors, backpressure, input scrambling and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decripta_bloco_seq;

  logic         clock = 1'b0;
  logic         reset;
  logic         entrada_valida;
  logic         entrada_pronta;
  logic [127:0] bloco_in;
  logic [127:0] chave;
  logic         saida_valida;
  logic         saida_pronta;
  logic [127:0] bloco_out;
  logic         ocupado;
`ifdef DECRIPTA_CONTADOR_EN
  logic [15:0]  blocos_decifrados;
`endif

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] C_K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C_P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C_C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] C_P2 = 128'h3243f6a8885a308d313198a2e0370734;

  decripta_bloco_seq #(.NUM_RODADAS(10), .LARGURA(128)) dut (
    .clock          (clock),
    .reset          (reset),
    .entrada_valida (entrada_valida),
    .entrada_pronta (entrada_pronta),
    .bloco_in       (bloco_in),
    .chave          (chave),
    .saida_valida   (saida_valida),
    .saida_pronta   (saida_pronta),
    .bloco_out      (bloco_out),
    .ocupado        (ocupado)
`ifdef DECRIPTA_CONTADOR_EN
    ,
    .blocos_decifrados (blocos_decifrados)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one block at a negedge; the following posedge is the accept edge.
  task automatic do_block(input logic [127:0] k, input logic [127:0] ct,
                          input logic [127:0] pt, input int stall,
                          input bit scramble, input string tag);
    int n;
    entrada_valida = 1'b1;
    chave          = k;
    bloco_in       = ct;
    saida_pronta   = (stall == 0);
    @(posedge clock);
    n = 0;
    @(negedge clock);
    check({tag, "_busy"}, {ocupado, entrada_pronta}, 128'b10);
    while (!saida_valida && n < 30) begin
      if (scramble) begin
        bloco_in       = {$urandom, $urandom, $urandom, $urandom};
        chave          = {$urandom, $urandom, $urandom, $urandom};
        entrada_valida = 1'($urandom_range(0, 1));
      end else begin
        entrada_valida = 1'b0;
      end
      @(posedge clock);
      n++;
      @(negedge clock);
    end
    entrada_valida = 1'b0;
    check({tag, "_latency"}, 128'(n), 128'd10);
    check({tag, "_data"}, bloco_out, pt);
    for (int i = 0; i < stall; i++) begin
      entrada_valida = 1'b1;
      bloco_in       = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clock);
      @(negedge clock);
      check({tag, "_hold"}, {saida_valida, entrada_pronta, bloco_out}, {1'b1, 1'b0, pt});
    end
    entrada_valida = 1'b0;
    saida_pronta   = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check({tag, "_done"}, {saida_valida, entrada_pronta, ocupado}, 128'b010);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset          = 1'b1;
    entrada_valida = 1'b0;
    saida_pronta   = 1'b0;
    bloco_in       = '0;
    chave          = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_pronta", entrada_pronta, 1'b1);
    check("rst_valida", saida_valida, 1'b0);
    check("rst_ocupado", ocupado, 1'b0);
    check("rst_out", bloco_out, '0);
    reset = 1'b0;

    do_block(C_K1, C_C1, C_P1, 0, 1'b0, "fips");
    do_block(C_K2, C_C2, C_P2, 0, 1'b0, "roundtrip");
    do_block(C_K2, C_C2, C_P2, 5, 1'b0, "backpressure");
    do_block(C_K1, C_C1, C_P1, 0, 1'b1, "scramble");

    // Reset sampled at edge 5 of a decryption.
    entrada_valida = 1'b1;
    chave          = C_K2;
    bloco_in       = C_C2;
    saida_pronta   = 1'b1;
    @(posedge clock);
    @(negedge clock);
    entrada_valida = 1'b0;
    repeat (4) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check("midrst_state", {saida_valida, entrada_pronta, ocupado}, 128'b010);
    check("midrst_out", bloco_out, '0);
    begin
      logic seen;
      seen = 1'b0;
      repeat (12) begin
        @(posedge clock);
        @(negedge clock);
        seen = seen | saida_valida;
      end
      check("midrst_nopulse", seen, 1'b0);
    end
    do_block(C_K1, C_C1, C_P1, 0, 1'b0, "after_rst");

`ifdef DECRIPTA_CONTADOR_EN
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check("cnt_rst", blocos_decifrados, 16'h0000);
    do_block(C_K1, C_C1, C_P1, 0, 1'b0, "cnt_a");
    do_block(C_K2, C_C2, C_P2, 0, 1'b0, "cnt_b");
    do_block(C_K1, C_C1, C_P1, 0, 1'b0, "cnt_c");
    check("cnt_three", blocos_decifrados, 16'd3);
    force dut.r_contador = 16'hffff;
    @(posedge clock);
    @(negedge clock);
    release dut.r_contador;
    do_block(C_K1, C_C1, C_P1, 0, 1'b0, "cnt_wrap");
    check("cnt_wrap_val", blocos_decifrados, 16'h0000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
